// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default widths,
// default queue depth and the fetch FSM state encoding.
package fetch_queue_pkg;

  localparam int FQ_ADDR_W = 32;
  localparam int FQ_DATA_W = 32;
  localparam int FQ_DEPTH  = 4;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_REQ  = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

  // True while a read is outstanding on the instruction memory bus.
  function automatic logic fq_state_busy(input fq_state_e s);
    return (s == FQ_REQ) || (s == FQ_DROP);
  endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with flush. Push and pop may happen in the same
// cycle at any fill level; flush empties the queue and overrides both.
// The head entry is presented combinationally from the storage array.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == {(PTR_W + 1){1'b0}});
  assign head_data = mem[rd_ptr];

  // A pop is only honoured with data present; a push into a full queue is
  // only honoured when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage array; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {(PTR_W + 1){1'b0}};
    end else if (flush) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage sitting right after the program counter. Issues
// one instruction-memory read at a time from the current PC, tags each
// returned word with its address into a small queue that decode drains,
// and holds the PC until a fetched word has actually been accepted.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int ADDR_W = FQ_ADDR_W,
  parameter int DATA_W = FQ_DATA_W,
  parameter int DEPTH  = FQ_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pcIn,
  input  logic              redirect,
  output logic              pcHold,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic              instrValid,
  output logic [DATA_W-1:0] instrData,
  output logic [ADDR_W-1:0] instrAddr,
  input  logic              instrReady
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fq_state_e                  state_r;
  fq_state_e                  state_next;
  logic [ADDR_W-1:0]          mem_addr_r;
  logic                       mem_req_r;
  logic                       latch_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       pc_hold_s;
  logic                       room_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [CNT_W-1:0]           fifo_count_s;
  logic [ADDR_W+DATA_W-1:0]   fifo_head_s;

  assign pop_s      = !fifo_empty_s && instrReady;
  assign room_s     = (fifo_count_s < FULL_CNT);
  assign pcHold     = pc_hold_s;
  assign memReq     = mem_req_r;
  assign memAddr    = mem_addr_r;
  assign instrValid = !fifo_empty_s;
  assign instrAddr  = fifo_head_s[ADDR_W+DATA_W-1:DATA_W];
  assign instrData  = fifo_head_s[DATA_W-1:0];

  // Next-state, push and PC-hold decode. The PC advances only when a word
  // is actually stored, so a word that cannot be kept is simply refetched.
  always_comb begin
    state_next = state_r;
    latch_s    = 1'b0;
    push_s     = 1'b0;
    pc_hold_s  = 1'b1;
    case (state_r)
      FQ_IDLE: begin
        if (room_s && !redirect) begin
          state_next = FQ_REQ;
          latch_s    = 1'b1;
        end else begin
          state_next = FQ_IDLE;
        end
      end
      FQ_REQ: begin
        if (memAck) begin
          state_next = FQ_IDLE;
          if (!redirect && (!fifo_full_s || pop_s)) begin
            push_s    = 1'b1;
            pc_hold_s = 1'b0;
          end else begin
            push_s    = 1'b0;
            pc_hold_s = 1'b1;
          end
        end else if (redirect) begin
          state_next = FQ_DROP;
        end else begin
          state_next = FQ_REQ;
        end
      end
      FQ_DROP: begin
        if (memAck) begin
          state_next = FQ_IDLE;
        end else begin
          state_next = FQ_DROP;
        end
      end
      default: begin
        state_next = FQ_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FQ_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Request strobe, registered so it follows the state it is issued from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_r <= 1'b0;
    end else begin
      mem_req_r <= fq_state_busy(state_next);
    end
  end

  // Fetch address is captured on issue and frozen until the read completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_r <= {ADDR_W{1'b0}};
    end else if (latch_s) begin
      mem_addr_r <= pcIn;
    end else begin
      mem_addr_r <= mem_addr_r;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({mem_addr_r, memData}),
    .pop       (pop_s),
    .flush     (redirect),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by a
// randomized run, all compared against a transaction-level queue model.
module tb_fetch_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pcIn;
  logic          redirect;
  logic          pcHold;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memAck;
  logic [DW-1:0] memData;
  logic          instrValid;
  logic [DW-1:0] instrData;
  logic [AW-1:0] instrAddr;
  logic          instrReady;

  fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcIn       (pcIn),
    .redirect   (redirect),
    .pcHold     (pcHold),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memAck     (memAck),
    .memData    (memData),
    .instrValid (instrValid),
    .instrData  (instrData),
    .instrAddr  (instrAddr),
    .instrReady (instrReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model: queued words, the one outstanding read, and the PC.
  ent_t          mq[$];
  bit            m_busy;
  bit            m_drop;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] pc;
  int            wait_cnt;
  int            lat_tgt;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Asynchronously assert reset, check reset values, clear the model.
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    memAck     = 1'b0;
    redirect   = 1'b0;
    instrReady = 1'b0;
    pcIn       = 32'h0;
    memData    = 32'h0;
    #1;
    chk("rst_memReq", memReq, 32'h0);
    chk("rst_instrValid", instrValid, 32'h0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_instrData", instrData, 32'h0);
    chk("rst_instrAddr", instrAddr, 32'h0);
    chk("rst_pcHold", pcHold, 32'h1);
    @(posedge clk);
    mq.delete();
    m_busy   = 1'b0;
    m_drop   = 1'b0;
    m_addr   = 32'h0;
    pc       = 32'h0;
    wait_cnt = 0;
    lat_tgt  = 0;
  endtask

  // One clock cycle. mode: 0 no ack, 1 ack when a read is outstanding,
  // 2 ack after a random latency, 3 spurious ack regardless of state.
  task automatic cycle(input bit rdy, input bit redir, input logic [AW-1:0] tgt, input int mode);
    bit ack;
    bit hold_exp;
    bit issue_ok;
    @(negedge clk);
    reset = 1'b0;
    case (mode)
      1:       ack = m_busy;
      2:       ack = m_busy && (wait_cnt >= lat_tgt);
      3:       ack = 1'b1;
      default: ack = 1'b0;
    endcase
    memAck     = ack;
    memData    = m_busy ? mem_word(m_addr) : 32'hDEAD_BEEF;
    pcIn       = pc;
    redirect   = redir;
    instrReady = rdy;
    hold_exp   = !(m_busy && !m_drop && ack && !redir);
    #1;
    chk("memReq", memReq, m_busy);
    if (m_busy) chk("memAddr", memAddr, m_addr);
    chk("pcHold", pcHold, hold_exp);
    chk("instrValid", instrValid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("instrAddr", instrAddr, mq[0].a);
      chk("instrData", instrData, mq[0].d);
    end
    @(posedge clk);
    issue_ok = (mq.size() < DEPTH) && !redir;
    if (redir) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (m_busy && !m_drop && ack) mq.push_back('{a: m_addr, d: mem_word(m_addr)});
    end
    if (m_busy) begin
      if (ack) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
      end else begin
        wait_cnt++;
        if (redir) m_drop = 1'b1;
      end
    end else if (issue_ok) begin
      m_busy   = 1'b1;
      m_drop   = 1'b0;
      m_addr   = pc;
      wait_cnt = 0;
      lat_tgt  = $urandom_range(0, 3);
    end
    if (redir) pc = tgt;
    else if (!hold_exp) pc = pc + 32'h1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pcIn = 32'h0; redirect = 1'b0; memAck = 1'b0;
    memData = 32'h0; instrReady = 1'b0; pc = 32'h0;
    m_busy = 1'b0; m_drop = 1'b0; m_addr = 32'h0; wait_cnt = 0; lat_tgt = 0;

    // In-order fetch from 0 with immediate acks and decode always ready.
    do_reset();
    repeat (16) cycle(1'b1, 1'b0, 32'h0, 1);

    // Decode stalled: exactly DEPTH words fetched, then fetching stops.
    do_reset();
    repeat (20) cycle(1'b0, 1'b0, 32'h0, 1);
    #1;
    chk("t2_memReq", memReq, 32'h0);
    chk("t2_pcHold", pcHold, 32'h1);
    chk("t2_lastAddr", memAddr, 32'h3);
    chk("t2_head", instrAddr, 32'h0);
    repeat (24) cycle(1'b1, 1'b0, 32'h0, 1);

    // Redirect with three queued words and a read outstanding.
    do_reset();
    for (int i = 0; i < 40 && !(mq.size() == 3 && m_busy); i++) cycle(1'b0, 1'b0, 32'h0, 1);
    chk("t3_setup", (mq.size() == 3 && m_busy), 32'h1);
    cycle(1'b0, 1'b1, 32'h100, 0);
    #1;
    chk("t3_flushed", instrValid, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 0);
    cycle(1'b1, 1'b0, 32'h0, 1);
    for (int i = 0; i < 10 && mq.size() == 0; i++) cycle(1'b1, 1'b0, 32'h0, 1);
    #1;
    chk("t3_first_addr", instrAddr, 32'h100);

    // Redirect coincident with the ack: word dropped, refetch from target.
    do_reset();
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1);
    cycle(1'b0, 1'b1, 32'h200, 1);
    #1;
    chk("t4_flushed", instrValid, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1);
    #1;
    chk("t4_memReq", memReq, 32'h1);
    chk("t4_memAddr", memAddr, 32'h200);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1);

    // Push and pop in the same cycle near and at full.
    do_reset();
    for (int i = 0; i < 40 && !(mq.size() == 3 && m_busy); i++) cycle(1'b0, 1'b0, 32'h0, 1);
    cycle(1'b1, 1'b0, 32'h0, 1);
    for (int i = 0; i < 40 && mq.size() < DEPTH; i++) cycle(1'b0, 1'b0, 32'h0, 1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1);
    repeat (12) cycle(1'b1, 1'b0, 32'h0, 1);

    // Reset during an outstanding read; a stale ack afterwards is ignored.
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 0);
    cycle(1'b1, 1'b0, 32'h0, 0);
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 3);
    for (int i = 0; i < 10 && mq.size() == 0; i++) cycle(1'b1, 1'b0, 32'h0, 1);
    #1;
    chk("t6_first_addr", instrAddr, 32'h0);
    chk("t6_first_data", instrData, mem_word(32'h0));

    // Randomized traffic: variable latency, stalls and redirects.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
            $urandom & 32'h0000_FFF0, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
